// File: rtl/pll_reset_seq_if.sv
// Signal bundle between the PLL reset sequencer and its PLL / design-block neighbours.
interface pll_reset_seq_if #(
   parameter int NUM_RST = 4
);
   logic               pll_locked;
   logic               soft_reset;
   logic               pll_rst;
   logic [NUM_RST-1:0] sys_rst;
   logic               ready;
   logic [7:0]         lock_lost_cnt;

   modport master (
      output pll_locked, soft_reset,
      input  pll_rst, sys_rst, ready, lock_lost_cnt
   );

   modport slave (
      input  pll_locked, soft_reset,
      output pll_rst, sys_rst, ready, lock_lost_cnt
   );
endinterface

// File: rtl/pll_reset_seq.sv
// PLL reset/lock supervisor on refclk: pulses the PLL, waits for stable lock, releases sys_rst in order.
// Optional macro PLL_LOCK_TIMEOUT_EN: re-pulse the PLL when lock never arrives in WAIT_LOCK.
module pll_reset_seq #(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int STAGGER_CYCLES      = 8,
   parameter int NUM_RST             = 4,
   parameter int LOCK_TIMEOUT_CYCLES = 1048576
) (
   input  logic           refclk,
   input  logic           rst_n,
   pll_reset_seq_if.slave bus
);
   localparam int REL_CYCLES = NUM_RST * STAGGER_CYCLES;
   localparam int MAX_A = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int MAX_B = (MAX_A > REL_CYCLES) ? MAX_A : REL_CYCLES;
`ifdef PLL_LOCK_TIMEOUT_EN
   localparam int MAX_C = (MAX_B > LOCK_TIMEOUT_CYCLES) ? MAX_B : LOCK_TIMEOUT_CYCLES;
`else
   localparam int MAX_C = MAX_B + (LOCK_TIMEOUT_CYCLES * 0);
`endif
   localparam int CNT_W = $clog2(MAX_C + 1);

   localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_END   = CNT_W'(LOCK_STABLE_CYCLES);
   localparam logic [CNT_W-1:0] REL_END      = CNT_W'(REL_CYCLES);
`ifdef PLL_LOCK_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TMO_END      = CNT_W'(LOCK_TIMEOUT_CYCLES);
`endif

   typedef enum logic [2:0] {
      S_PLL_RST,
      S_WAIT_LOCK,
      S_STABLE,
      S_RELEASE,
      S_RUN
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               lk_p0;
   logic               lk_p1;
   logic               pll_rst_q;
   logic [NUM_RST-1:0] sys_rst_q;
   logic               ready_q;
   logic [7:0]         lost_cnt_q;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Bits still held in reset after n release cycles; monotone in n, so releases never glitch.
   function automatic logic [NUM_RST-1:0] rel_mask(input logic [CNT_W-1:0] n);
      logic [NUM_RST-1:0] m;
      m = '1;
      for (int k = 0; k < NUM_RST; k++) begin
         m[k] = (n < CNT_W'((k + 1) * STAGGER_CYCLES));
      end
      return m;
   endfunction

   assign cnt_nxt = cnt + CNT_W'(1);

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         lk_p0      <= 1'b0;
         lk_p1      <= 1'b0;
         state      <= S_PLL_RST;
         cnt        <= '0;
         pll_rst_q  <= 1'b1;
         sys_rst_q  <= '1;
         ready_q    <= 1'b0;
         lost_cnt_q <= '0;
      end else begin
         // stage p0/p1: two-flop lock synchronizer, lk_p1 feeds every decision
         lk_p0 <= bus.pll_locked;
         lk_p1 <= lk_p0;
         case (state)
            S_PLL_RST: begin
               if (cnt == PLL_RST_LAST) begin
                  state     <= S_WAIT_LOCK;
                  cnt       <= '0;
                  pll_rst_q <= 1'b0;
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            S_WAIT_LOCK: begin
               if (lk_p1) begin
                  state <= S_STABLE;
                  cnt   <= '0;
               end
`ifdef PLL_LOCK_TIMEOUT_EN
               else if (cnt_nxt == TMO_END) begin
                  state     <= S_PLL_RST;
                  cnt       <= '0;
                  pll_rst_q <= 1'b1;
               end else begin
                  cnt <= cnt_nxt;
               end
`endif
            end
            S_STABLE: begin
               if (!lk_p1) begin
                  state <= S_WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt_nxt == STABLE_END) begin
                  state <= S_RELEASE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            S_RELEASE, S_RUN: begin
               if (!lk_p1) begin
                  state      <= S_PLL_RST;
                  cnt        <= '0;
                  pll_rst_q  <= 1'b1;
                  sys_rst_q  <= '1;
                  ready_q    <= 1'b0;
                  lost_cnt_q <= sat_inc8(lost_cnt_q);
               end else if (state == S_RELEASE) begin
                  sys_rst_q <= rel_mask(cnt_nxt);
                  if (cnt_nxt == REL_END) begin
                     state   <= S_RUN;
                     cnt     <= '0;
                     ready_q <= 1'b1;
                  end else begin
                     cnt <= cnt_nxt;
                  end
               end else if (bus.soft_reset) begin
                  state     <= S_STABLE;
                  cnt       <= '0;
                  sys_rst_q <= '1;
                  ready_q   <= 1'b0;
               end
            end
            default: state <= S_PLL_RST;
         endcase
      end
   end

   assign bus.pll_rst       = pll_rst_q;
   assign bus.sys_rst       = sys_rst_q;
   assign bus.ready         = ready_q;
   assign bus.lock_lost_cnt = lost_cnt_q;
endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq: power-up, lock glitch, lock loss, soft reset, saturation, timeout, async reset.
module tb_pll_reset_seq;
`ifdef PLL_LOCK_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic refclk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   int   exp_cnt;

   pll_reset_seq_if #(.NUM_RST(4)) bus ();

   pll_reset_seq #(
      .PLL_RST_CYCLES     (4),
      .LOCK_STABLE_CYCLES (8),
      .STAGGER_CYCLES     (2),
      .NUM_RST            (4),
      .LOCK_TIMEOUT_CYCLES(32)
   ) dut (
      .refclk(refclk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   task automatic tick(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b1;
      bus.pll_locked = 1'b0;
      bus.soft_reset = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_pll_rst", bus.pll_rst, 1);
      chk("rst_sys_rst", bus.sys_rst, 4'hF);
      chk("rst_ready", bus.ready, 0);
      chk("rst_cnt", bus.lock_lost_cnt, 0);
      tick(3);
      chk("rst_hold_pll_rst", bus.pll_rst, 1);
      rst_n = 1'b1;

      // power-up sequence
      tick(1);  chk("pu_pll_rst_c1", bus.pll_rst, 1);
      tick(2);  chk("pu_pll_rst_c3", bus.pll_rst, 1);
      tick(1);  chk("pu_pll_rst_c4", bus.pll_rst, 0);
      tick(6);  bus.pll_locked = 1'b1;
      tick(12); chk("pu_sys_c22", bus.sys_rst, 4'hF);
      tick(1);  chk("pu_sys_c23", bus.sys_rst, 4'hE);
      tick(1);  chk("pu_sys_c24", bus.sys_rst, 4'hE);
      tick(1);  chk("pu_sys_c25", bus.sys_rst, 4'hC);
      tick(2);  chk("pu_sys_c27", bus.sys_rst, 4'h8);
      tick(1);  chk("pu_sys_c28", bus.sys_rst, 4'h8);
                chk("pu_ready_c28", bus.ready, 0);
      tick(1);  chk("pu_sys_c29", bus.sys_rst, 4'h0);
                chk("pu_ready_c29", bus.ready, 1);
                chk("pu_cnt", bus.lock_lost_cnt, 0);

      // lock glitch during STABLE
      rst_n = 1'b0;
      bus.pll_locked = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(4);  bus.pll_locked = 1'b1;
      tick(6);  bus.pll_locked = 1'b0;
      tick(3);  bus.pll_locked = 1'b1;
      tick(10); chk("gl_sys_c23", bus.sys_rst, 4'hF);
      tick(3);  chk("gl_sys_c26", bus.sys_rst, 4'hE);
                chk("gl_cnt", bus.lock_lost_cnt, 0);
      tick(6);  chk("gl_ready_c32", bus.ready, 1);
                chk("gl_sys_c32", bus.sys_rst, 4'h0);

      // lock loss in RUN
      bus.pll_locked = 1'b0;
      tick(2);  chk("ll_ready_e2", bus.ready, 1);
      tick(1);  chk("ll_sys_e3", bus.sys_rst, 4'hF);
                chk("ll_ready_e3", bus.ready, 0);
                chk("ll_pll_rst_e3", bus.pll_rst, 1);
                chk("ll_cnt_e3", bus.lock_lost_cnt, 1);
      tick(3);  chk("ll_pll_rst_e6", bus.pll_rst, 1);
      tick(1);  chk("ll_pll_rst_e7", bus.pll_rst, 0);
      bus.pll_locked = 1'b1;
      tick(18); chk("ll_sys_f18", bus.sys_rst, 4'h8);
                chk("ll_ready_f18", bus.ready, 0);
      tick(1);  chk("ll_sys_f19", bus.sys_rst, 4'h0);
                chk("ll_ready_f19", bus.ready, 1);

      // soft reset in RUN
      bus.soft_reset = 1'b1;
      tick(1);  bus.soft_reset = 1'b0;
                chk("sr_sys_g1", bus.sys_rst, 4'hF);
                chk("sr_ready_g1", bus.ready, 0);
                chk("sr_pll_rst_g1", bus.pll_rst, 0);
                chk("sr_cnt_g1", bus.lock_lost_cnt, 1);
      tick(4);  chk("sr_pll_rst_g5", bus.pll_rst, 0);
      tick(5);  chk("sr_sys_g10", bus.sys_rst, 4'hF);
      tick(1);  chk("sr_sys_g11", bus.sys_rst, 4'hE);
      tick(5);  chk("sr_ready_g16", bus.ready, 0);
      tick(1);  chk("sr_ready_g17", bus.ready, 1);
                chk("sr_sys_g17", bus.sys_rst, 4'h0);

      // soft reset held outside RUN is ignored
      bus.pll_locked = 1'b0;
      tick(3);  chk("sw_cnt_h3", bus.lock_lost_cnt, 2);
      tick(4);  chk("sw_pll_rst_h7", bus.pll_rst, 0);
      bus.soft_reset = 1'b1;
      tick(5);  chk("sw_sys_h12", bus.sys_rst, 4'hF);
                chk("sw_pll_rst_h12", bus.pll_rst, 0);
                chk("sw_cnt_h12", bus.lock_lost_cnt, 2);
      bus.pll_locked = 1'b1;
      tick(17); bus.soft_reset = 1'b0;
      tick(1);  chk("sw_sys_k18", bus.sys_rst, 4'h8);
      tick(1);  chk("sw_ready_k19", bus.ready, 1);
                chk("sw_cnt_k19", bus.lock_lost_cnt, 2);

      // simultaneous soft reset and lock loss
      bus.pll_locked = 1'b0;
      tick(2);  bus.soft_reset = 1'b1;
      tick(1);  bus.soft_reset = 1'b0;
                chk("sim_cnt", bus.lock_lost_cnt, 3);
                chk("sim_pll_rst", bus.pll_rst, 1);
                chk("sim_sys", bus.sys_rst, 4'hF);

      // saturation of the lock-loss counter
      exp_cnt = 3;
      for (int i = 0; i < 256; i++) begin
         bus.pll_locked = 1'b1;
         tick(25);
         chk("sat_ready", bus.ready, 1);
         bus.pll_locked = 1'b0;
         tick(3);
         exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
         chk("sat_cnt", bus.lock_lost_cnt, exp_cnt);
      end
      chk("sat_final", bus.lock_lost_cnt, 255);

      // asynchronous reset mid-RELEASE
      bus.pll_locked = 1'b1;
      tick(16); chk("ar_sys_mid", bus.sys_rst, 4'hE);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_pll_rst", bus.pll_rst, 1);
      chk("ar_sys", bus.sys_rst, 4'hF);
      chk("ar_ready", bus.ready, 0);
      chk("ar_cnt", bus.lock_lost_cnt, 0);
      bus.pll_locked = 1'b0;
      tick(2);
      rst_n = 1'b1;

      // no lock: timeout re-pulse only when enabled
      tick(4);  chk("to_pll_rst_p4", bus.pll_rst, 0);
      tick(31); chk("to_pll_rst_p35", bus.pll_rst, 0);
      tick(1);  chk("to_pll_rst_p36", bus.pll_rst, TMO_EN ? 1 : 0);
      tick(3);  chk("to_pll_rst_p39", bus.pll_rst, TMO_EN ? 1 : 0);
      tick(1);  chk("to_pll_rst_p40", bus.pll_rst, 0);
      tick(32); chk("to_pll_rst_p72", bus.pll_rst, TMO_EN ? 1 : 0);
                chk("to_cnt", bus.lock_lost_cnt, 0);
                chk("to_sys", bus.sys_rst, 4'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
